// File: rtl/sll32_iter.sv
// Iterative 32-bit logical left shifter: one log-shifter stage per clock
// (16, 8, 4, 2, 1), fixed 5-cycle latency, sticky shifted-out-ones flag.
module sll32_iter (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_start,
  input  logic [31:0] data_input,
  input  logic [4:0]  ctrl_shiftamt,
  output logic [31:0] data_sll,
  output logic        data_overflow,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] work_q, work_d;
  logic [4:0]  amt_q, amt_d;
  logic        ovf_q, ovf_d;

  logic        accept;
  logic        stage_bit;
  logic [31:0] stage_sh;
  logic        stage_lost;

  // DONE accepts like IDLE, which is what gives 6-cycle back-to-back issue.
  assign accept = ctrl_start && (state_q == S_IDLE || state_q == S_DONE);

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_SHIFT;
      S_SHIFT: if (k_q == 3'd4) state_d = S_DONE;
      S_DONE:  state_d = accept ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Current stage: amount bit 4-k, distance 16>>k, plus the MSBs it discards.
  always_comb begin
    stage_bit  = 1'b0;
    stage_sh   = work_q;
    stage_lost = 1'b0;
    case (k_q)
      3'd0: begin
        stage_bit  = amt_q[4];
        stage_sh   = {work_q[15:0], 16'h0000};
        stage_lost = |work_q[31:16];
      end
      3'd1: begin
        stage_bit  = amt_q[3];
        stage_sh   = {work_q[23:0], 8'h00};
        stage_lost = |work_q[31:24];
      end
      3'd2: begin
        stage_bit  = amt_q[2];
        stage_sh   = {work_q[27:0], 4'h0};
        stage_lost = |work_q[31:28];
      end
      3'd3: begin
        stage_bit  = amt_q[1];
        stage_sh   = {work_q[29:0], 2'b00};
        stage_lost = |work_q[31:30];
      end
      3'd4: begin
        stage_bit  = amt_q[0];
        stage_sh   = {work_q[30:0], 1'b0};
        stage_lost = work_q[31];
      end
      default: begin
        stage_bit  = 1'b0;
        stage_sh   = work_q;
        stage_lost = 1'b0;
      end
    endcase
  end

  always_comb begin
    k_d    = k_q;
    work_d = work_q;
    amt_d  = amt_q;
    ovf_d  = ovf_q;
    if (accept) begin
      work_d = data_input;
      amt_d  = ctrl_shiftamt;
      ovf_d  = 1'b0;
      k_d    = 3'd0;
    end else if (state_q == S_SHIFT) begin
      if (stage_bit) begin
        work_d = stage_sh;
        ovf_d  = ovf_q | stage_lost;
      end
      k_d = (k_q == 3'd4) ? 3'd0 : k_q + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      k_q    <= 3'd0;
      work_q <= 32'h0;
      amt_q  <= 5'd0;
      ovf_q  <= 1'b0;
    end else begin
      k_q    <= k_d;
      work_q <= work_d;
      amt_q  <= amt_d;
      ovf_q  <= ovf_d;
    end
  end

  // Outputs decode only registered state, so nothing flows through from inputs.
  always_comb begin
    data_sll       = work_q;
    data_overflow  = ovf_q;
    data_resultRDY = (state_q == S_DONE);
    busy           = (state_q == S_SHIFT);
  end

endmodule

// File: tb/tb_sll32_iter.sv
// Directed bench for sll32_iter: latency, result, overflow, busy-drop, reset abort, back-to-back.
module tb_sll32_iter;

  logic        clock;
  logic        reset;
  logic        ctrl_start;
  logic [31:0] data_input;
  logic [4:0]  ctrl_shiftamt;
  logic [31:0] data_sll;
  logic        data_overflow;
  logic        data_resultRDY;
  logic        busy;

  int checks;
  int errors;

  sll32_iter dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_start     (ctrl_start),
    .data_input     (data_input),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .data_sll       (data_sll),
    .data_overflow  (data_overflow),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive a one-cycle start; returns #1 after the accept edge with start low.
  task automatic launch(input logic [31:0] op, input logic [4:0] amt);
    ctrl_start    = 1'b1;
    data_input    = op;
    ctrl_shiftamt = amt;
    @(posedge clock);
    #1;
    ctrl_start = 1'b0;
  endtask

  // Cycles from the last edge until ready is seen (-1 on timeout); counts busy cycles too.
  task automatic wait_ready(output int lat, output int busy_cycles);
    lat = -1;
    busy_cycles = 0;
    if (busy) busy_cycles++;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        lat = i;
        break;
      end
      if (busy) busy_cycles++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ctrl_start = 1'b1;
    data_input = 32'hDEADBEEF;
    ctrl_shiftamt = 5'd3;
    repeat (2) @(posedge clock);
    #1;
    ctrl_start = 1'b0;
    reset = 1'b0;
    checks++; if (data_sll !== 32'h0) begin errors++; $display("FAIL reset_sll: got %h expected %h", data_sll, 32'h0); end
    checks++; if (data_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", data_overflow); end
    checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", data_resultRDY); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_max_shift;
    int lat, bc;
    launch(32'h00000001, 5'd31);
    wait_ready(lat, bc);
    checks++; if (bc !== 5) begin errors++; $display("FAIL max_busy_cycles: got %0d expected 5", bc); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL max_latency: got %0d expected 5", lat); end
    checks++; if (data_sll !== 32'h80000000) begin errors++; $display("FAIL max_sll: got %h expected %h", data_sll, 32'h80000000); end
    checks++; if (data_overflow !== 1'b0) begin errors++; $display("FAIL max_ovf: got %b expected 0", data_overflow); end
    @(posedge clock);
    #1;
    checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL max_rdy_pulse: got %b expected 0", data_resultRDY); end
    checks++; if (data_sll !== 32'h80000000) begin errors++; $display("FAIL max_hold: got %h expected %h", data_sll, 32'h80000000); end
  endtask

  task automatic test_overflow;
    int lat, bc;
    launch(32'hFFFFFFFF, 5'd4);
    wait_ready(lat, bc);
    checks++; if (lat !== 5) begin errors++; $display("FAIL ovf_latency: got %0d expected 5", lat); end
    checks++; if (data_sll !== 32'hFFFFFFF0) begin errors++; $display("FAIL ovf_sll: got %h expected %h", data_sll, 32'hFFFFFFF0); end
    checks++; if (data_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", data_overflow); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_zero_shift;
    int lat, bc;
    launch(32'h12345678, 5'd0);
    wait_ready(lat, bc);
    checks++; if (lat !== 5) begin errors++; $display("FAIL zero_latency: got %0d expected 5", lat); end
    checks++; if (data_sll !== 32'h12345678) begin errors++; $display("FAIL zero_sll: got %h expected %h", data_sll, 32'h12345678); end
    checks++; if (data_overflow !== 1'b0) begin errors++; $display("FAIL zero_ovf: got %b expected 0", data_overflow); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_ignore_busy;
    int pulses, first_lat;
    logic [31:0] res;
    logic ovf;
    pulses = 0; first_lat = -1; res = 32'hX; ovf = 1'bX;
    launch(32'h0000000F, 5'd8);
    for (int i = 1; i <= 12; i++) begin
      if (i == 2) begin
        ctrl_start = 1'b1; data_input = 32'hFFFFFFFF; ctrl_shiftamt = 5'd1;
      end else if (i == 3) begin
        ctrl_start = 1'b0; data_input = 32'hA5A5A5A5; ctrl_shiftamt = 5'd17;
      end
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        pulses++;
        if (first_lat < 0) begin first_lat = i; res = data_sll; ovf = data_overflow; end
      end
    end
    ctrl_start = 1'b0;
    checks++; if (pulses !== 1) begin errors++; $display("FAIL busy_pulses: got %0d expected 1", pulses); end
    checks++; if (first_lat !== 5) begin errors++; $display("FAIL busy_latency: got %0d expected 5", first_lat); end
    checks++; if (res !== 32'h00000F00) begin errors++; $display("FAIL busy_sll: got %h expected %h", res, 32'h00000F00); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL busy_ovf: got %b expected 0", ovf); end
  endtask

  task automatic test_reset_abort;
    int pulses;
    pulses = 0;
    launch(32'h00010000, 5'd16);
    @(posedge clock);
    #1;
    reset = 1'b1;
    ctrl_start = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    ctrl_start = 1'b0;
    checks++; if (data_sll !== 32'h0) begin errors++; $display("FAIL abort_sll: got %h expected %h", data_sll, 32'h0); end
    checks++; if (data_overflow !== 1'b0) begin errors++; $display("FAIL abort_ovf: got %b expected 0", data_overflow); end
    checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL abort_rdy: got %b expected 0", data_resultRDY); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_ready: got %0d expected 0", pulses); end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2, bc;
    launch(32'h80000001, 5'd1);
    wait_ready(lat1, bc);
    checks++; if (lat1 !== 5) begin errors++; $display("FAIL b2b_lat1: got %0d expected 5", lat1); end
    checks++; if (data_sll !== 32'h00000002) begin errors++; $display("FAIL b2b_sll1: got %h expected %h", data_sll, 32'h00000002); end
    checks++; if (data_overflow !== 1'b1) begin errors++; $display("FAIL b2b_ovf1: got %b expected 1", data_overflow); end
    launch(32'h00000003, 5'd2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", busy); end
    checks++; if (data_overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf_clear: got %b expected 0", data_overflow); end
    wait_ready(lat2, bc);
    checks++; if (lat1 + 1 + lat2 > 12 || lat2 !== 5) begin errors++; $display("FAIL b2b_lat2: got %0d expected 5", lat2); end
    checks++; if (data_sll !== 32'h0000000C) begin errors++; $display("FAIL b2b_sll2: got %h expected %h", data_sll, 32'h0000000C); end
    checks++; if (data_overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf2: got %b expected 0", data_overflow); end
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    ctrl_start = 1'b0;
    data_input = 32'h0;
    ctrl_shiftamt = 5'd0;
    #1;
    test_reset;
    test_max_shift;
    test_overflow;
    test_zero_shift;
    test_ignore_busy;
    test_reset_abort;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
